// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds FSM state codes, WB data-select codes and forwarding-select codes.
// Also provides the register-match helper used by the forwarding and load-use logic.
package pipe_pkg;

    // FSM state codes
    typedef logic [1:0] state_t;
    localparam state_t RUN     = 2'd0;
    localparam state_t LDSTALL = 2'd1;
    localparam state_t MEMWAIT = 2'd2;
    localparam state_t ERR     = 2'd3;

    // WB data-select codes carried with the EX instruction
    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC4 = 2'b10;

    // EX operand source-select codes
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // True when a stage writes a real (non-x0) register that matches src
    function automatic logic reg_hit(input logic wr_en, input logic [4:0] wraddr,
                                     input logic [4:0] src);
        return wr_en && (wraddr != 5'd0) && (wraddr == src);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-controller signal bundle between the datapath and pipe_ctrl.
// Purely combinational wiring, no storage.
// The master drives stage info and consumes enables; the slave is the controller.
interface pipe_ctrl_if;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic        ID_use_rs;
    logic        ID_use_rt;
    logic [4:0]  EX_rs;
    logic [4:0]  EX_rt;
    logic [4:0]  EX_wraddr;
    logic        EX_wr_en;
    logic [1:0]  EX_sel_data;
    logic [4:0]  MEM_wraddr;
    logic        MEM_wr_en;
    logic [4:0]  WB_wraddr;
    logic        WB_wr_en;
    logic        EX_br_taken;
    logic        dmem_req;
    logic        dmem_ack;
    logic        pc_en;
    logic        IF_ID_en;
    logic        ID_EX_en;
    logic        EX_MEM_en;
    logic        MEM_WB_en;
    logic        IF_ID_flush;
    logic        ID_EX_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        dmem_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] freeze_cnt;
`endif

    modport master (
        output ID_rs, ID_rt, ID_use_rs, ID_use_rt, EX_rs, EX_rt, EX_wraddr, EX_wr_en,
               EX_sel_data, MEM_wraddr, MEM_wr_en, WB_wraddr, WB_wr_en, EX_br_taken,
               dmem_req, dmem_ack,
        input  pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush,
               fwd_a, fwd_b, dmem_err
`ifdef PIPE_CTRL_PERF_EN
        , stall_cnt, flush_cnt, freeze_cnt
`endif
    );

    modport slave (
        input  ID_rs, ID_rt, ID_use_rs, ID_use_rt, EX_rs, EX_rt, EX_wraddr, EX_wr_en,
               EX_sel_data, MEM_wraddr, MEM_wr_en, WB_wraddr, WB_wr_en, EX_br_taken,
               dmem_req, dmem_ack,
        output pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush,
               fwd_a, fwd_b, dmem_err
`ifdef PIPE_CTRL_PERF_EN
        , stall_cnt, flush_cnt, freeze_cnt
`endif
    );
endinterface

// File: rtl/fwd_unit.sv
// Forwarding select for one EX operand: MEM result, else WB result, else regfile.
// Purely combinational, zero cycles.
// No flow control; output is valid whenever inputs are.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] mem_wraddr,
    input  logic       mem_wr_en,
    input  logic [4:0] wb_wraddr,
    input  logic       wb_wr_en,
    output logic [1:0] fwd
);

    // Youngest producer wins: MEM is newer than WB
    always_comb begin
        fwd = FWD_RF;
        if (reg_hit(mem_wr_en, mem_wraddr, src)) begin
            fwd = FWD_MEM;
        end else if (reg_hit(wb_wr_en, wb_wraddr, src)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, dmem freeze/timeout, forwarding.
// Stage enables and forwarding selects are combinational; FSM state updates each clk.
// A dmem request without ack freezes every stage; optional PIPE_CTRL_PERF_EN adds event counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t              state;
    state_t              state_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_cnt_nxt;
    logic                err_q;
    logic                active;
    logic                load_use;
    logic                freeze;
    logic                flush_br;
    logic                stall;
    logic                timeout;

    // Event decode; priority is freeze, then branch flush, then load-use
    always_comb begin
        active   = (state != ERR);
        load_use = (bus.EX_sel_data == SEL_MEM) &&
                   ((bus.ID_use_rs && reg_hit(bus.EX_wr_en, bus.EX_wraddr, bus.ID_rs)) ||
                    (bus.ID_use_rt && reg_hit(bus.EX_wr_en, bus.EX_wraddr, bus.ID_rt)));
        freeze   = active && bus.dmem_req && !bus.dmem_ack;
        flush_br = active && !freeze && bus.EX_br_taken;
        // A load stalls once: LDSTALL masks the hazard that is still visible
        stall    = active && !freeze && !bus.EX_br_taken && load_use && (state != LDSTALL);
        timeout  = freeze && (wait_cnt == WAIT_W'(TIMEOUT - 1));
    end

    // Stage-register enables and bubble inserts
    always_comb begin
        bus.pc_en       = active && !freeze && !stall;
        bus.IF_ID_en    = active && !freeze && !stall;
        bus.ID_EX_en    = active && !freeze;
        bus.EX_MEM_en   = active && !freeze;
        bus.MEM_WB_en   = active && !freeze;
        bus.IF_ID_flush = flush_br;
        bus.ID_EX_flush = flush_br || stall;
        bus.dmem_err    = err_q;
    end

    // Next-state and consecutive-freeze counter
    always_comb begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
        if (!active) begin
            state_nxt = ERR;
        end else if (timeout) begin
            state_nxt = ERR;
        end else if (freeze) begin
            state_nxt    = MEMWAIT;
            wait_cnt_nxt = wait_cnt + 1'b1;
        end else if (stall) begin
            state_nxt = LDSTALL;
        end
    end

    // State registers; ERR is left only through rst
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            err_q    <= err_q || timeout;
        end
    end

    fwd_unit u_fwd_a (
        .src        (bus.EX_rs),
        .mem_wraddr (bus.MEM_wraddr),
        .mem_wr_en  (bus.MEM_wr_en),
        .wb_wraddr  (bus.WB_wraddr),
        .wb_wr_en   (bus.WB_wr_en),
        .fwd        (bus.fwd_a)
    );

    fwd_unit u_fwd_b (
        .src        (bus.EX_rt),
        .mem_wraddr (bus.MEM_wraddr),
        .mem_wr_en  (bus.MEM_wr_en),
        .wb_wraddr  (bus.WB_wraddr),
        .wb_wr_en   (bus.WB_wr_en),
        .fwd        (bus.fwd_b)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic [31:0] freeze_cnt_q;

    // Free-running event counters, wrap naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (stall)    stall_cnt_q  <= stall_cnt_q + 32'd1;
            if (flush_br) flush_cnt_q  <= flush_cnt_q + 32'd1;
            if (freeze)   freeze_cnt_q <= freeze_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;
    assign bus.freeze_cnt = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with TIMEOUT=4.
// Inputs change 1ns after each rising edge and outputs are checked 1ns later.
// Control outputs are compared as {pc_en,IF_ID_en,ID_EX_en,EX_MEM_en,MEM_WB_en,IF_ID_flush,ID_EX_flush}.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    localparam logic [6:0] RUN_O = 7'b11111_00;
    localparam logic [6:0] LDS_O = 7'b00111_01;
    localparam logic [6:0] FRZ_O = 7'b00000_00;
    localparam logic [6:0] BR_O  = 7'b11111_11;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    logic [6:0] ctl;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign ctl = {bus.pc_en, bus.IF_ID_en, bus.ID_EX_en, bus.EX_MEM_en, bus.MEM_WB_en,
                  bus.IF_ID_flush, bus.ID_EX_flush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.ID_rs = 5'd0;       bus.ID_rt = 5'd0;
        bus.ID_use_rs = 1'b0;   bus.ID_use_rt = 1'b0;
        bus.EX_rs = 5'd0;       bus.EX_rt = 5'd0;
        bus.EX_wraddr = 5'd0;   bus.EX_wr_en = 1'b0;   bus.EX_sel_data = SEL_ALU;
        bus.MEM_wraddr = 5'd0;  bus.MEM_wr_en = 1'b0;
        bus.WB_wraddr = 5'd0;   bus.WB_wr_en = 1'b0;
        bus.EX_br_taken = 1'b0;
        bus.dmem_req = 1'b0;    bus.dmem_ack = 1'b0;
    endtask

    task automatic set_load_use();
        bus.EX_sel_data = SEL_MEM; bus.EX_wr_en = 1'b1; bus.EX_wraddr = 5'd8;
        bus.ID_rs = 5'd8;          bus.ID_use_rs = 1'b1;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("reset_ctl", 32'(ctl), 32'(RUN_O));
        chk("reset_err", 32'(bus.dmem_err), 32'd0);
        chk("reset_fwd", 32'({bus.fwd_a, bus.fwd_b}), 32'd0);

        // Load-use on rs: exactly one stall cycle
        tick(); set_load_use(); settle();
        chk("lu_stall", 32'(ctl), 32'(LDS_O));
        tick(); settle();
        chk("lu_masked", 32'(ctl), 32'(RUN_O));
        tick(); idle(); settle();
        chk("lu_after", 32'(ctl), 32'(RUN_O));

        // No stall for x0 destination, unused rs, or non-load producer
        tick(); set_load_use(); bus.EX_wraddr = 5'd0; bus.ID_rs = 5'd0; settle();
        chk("lu_x0", 32'(ctl), 32'(RUN_O));
        tick(); set_load_use(); bus.ID_use_rs = 1'b0; settle();
        chk("lu_nouse", 32'(ctl), 32'(RUN_O));
        tick(); set_load_use(); bus.EX_sel_data = SEL_ALU; settle();
        chk("lu_alu", 32'(ctl), 32'(RUN_O));

        // Load-use on rt
        tick(); idle(); bus.EX_sel_data = SEL_MEM; bus.EX_wr_en = 1'b1; bus.EX_wraddr = 5'd9;
        bus.ID_rt = 5'd9; bus.ID_use_rt = 1'b1; settle();
        chk("lu_rt", 32'(ctl), 32'(LDS_O));
        tick(); idle(); settle();
        chk("lu_rt_after", 32'(ctl), 32'(RUN_O));

        // Freeze 3 cycles, ack on the 4th
        for (int i = 0; i < 3; i++) begin
            tick(); idle(); bus.dmem_req = 1'b1; settle();
            chk($sformatf("frz_%0d", i), 32'(ctl), 32'(FRZ_O));
        end
        tick(); bus.dmem_ack = 1'b1; settle();
        chk("frz_ack", 32'(ctl), 32'(RUN_O));
        tick(); idle(); settle();
        chk("frz_done", 32'(ctl), 32'(RUN_O));
        chk("frz_noerr", 32'(bus.dmem_err), 32'd0);

        // Branch beats load-use and does not enter LDSTALL
        tick(); set_load_use(); bus.EX_br_taken = 1'b1; settle();
        chk("br_lu", 32'(ctl), 32'(BR_O));
        tick(); bus.EX_br_taken = 1'b0; settle();
        chk("br_then_lu", 32'(ctl), 32'(LDS_O));
        tick(); idle(); settle();
        chk("br_lu_clear", 32'(ctl), 32'(RUN_O));

        // Freeze beats branch
        tick(); bus.EX_br_taken = 1'b1; bus.dmem_req = 1'b1; settle();
        chk("frz_over_br", 32'(ctl), 32'(FRZ_O));
        tick(); bus.dmem_ack = 1'b1; settle();
        chk("br_on_ack", 32'(ctl), 32'(BR_O));

        // Forwarding, including during a freeze
        tick(); idle(); bus.EX_rs = 5'd5; bus.MEM_wraddr = 5'd5; bus.WB_wraddr = 5'd5;
        bus.MEM_wr_en = 1'b1; bus.WB_wr_en = 1'b1; settle();
        chk("fwd_a_mem", 32'(bus.fwd_a), 32'(2'b10));
        chk("fwd_b_rf", 32'(bus.fwd_b), 32'(2'b00));
        tick(); bus.MEM_wr_en = 1'b0; settle();
        chk("fwd_a_wb", 32'(bus.fwd_a), 32'(2'b01));
        tick(); bus.EX_rs = 5'd0; settle();
        chk("fwd_a_rf", 32'(bus.fwd_a), 32'(2'b00));
        tick(); bus.EX_rs = 5'd0; bus.MEM_wraddr = 5'd0; bus.MEM_wr_en = 1'b1;
        bus.WB_wraddr = 5'd0; settle();
        chk("fwd_a_x0", 32'(bus.fwd_a), 32'(2'b00));
        tick(); bus.EX_rt = 5'd7; bus.MEM_wraddr = 5'd3; bus.WB_wraddr = 5'd7; settle();
        chk("fwd_b_wb", 32'(bus.fwd_b), 32'(2'b01));
        tick(); bus.MEM_wraddr = 5'd7; bus.EX_rs = 5'd7; bus.dmem_req = 1'b1; settle();
        chk("fwd_b_frz", 32'(bus.fwd_b), 32'(2'b10));
        chk("fwd_a_frz", 32'(bus.fwd_a), 32'(2'b10));
        chk("fwd_frz_ctl", 32'(ctl), 32'(FRZ_O));
        tick(); idle(); settle();
        chk("fwd_done", 32'(ctl), 32'(RUN_O));

        // Reset in the middle of a freeze clears the wait counter
        for (int i = 0; i < 2; i++) begin
            tick(); bus.dmem_req = 1'b1; settle();
        end
        tick(); rst = 1'b1; settle();
        tick(); rst = 1'b0; settle();
        chk("rst_mw_ctl", 32'(ctl), 32'(FRZ_O));
        for (int i = 0; i < 2; i++) begin
            tick(); settle();
        end
        chk("rst_mw_noerr", 32'(bus.dmem_err), 32'd0);
        tick(); bus.dmem_ack = 1'b1; settle();
        chk("rst_mw_ack", 32'(ctl), 32'(RUN_O));
        chk("rst_mw_err", 32'(bus.dmem_err), 32'd0);

        // Timeout: 4 freeze cycles, then sticky ERR
        for (int i = 0; i < 4; i++) begin
            tick(); idle(); bus.dmem_req = 1'b1; settle();
            chk($sformatf("to_frz_%0d", i), 32'(ctl), 32'(FRZ_O));
            chk($sformatf("to_err_lo_%0d", i), 32'(bus.dmem_err), 32'd0);
        end
        tick(); settle();
        chk("to_err", 32'(bus.dmem_err), 32'd1);
        chk("to_err_ctl", 32'(ctl), 32'(FRZ_O));
        tick(); idle(); bus.dmem_ack = 1'b1; bus.EX_br_taken = 1'b1; settle();
        chk("err_hold_ctl", 32'(ctl), 32'(FRZ_O));
        tick(); idle(); settle();
        chk("err_hold", 32'(bus.dmem_err), 32'd1);

        // Reset out of ERR: first cycle decodes as RUN
        tick(); rst = 1'b1; settle();
        tick(); rst = 1'b0; settle();
        chk("err_rst_ctl", 32'(ctl), 32'(RUN_O));
        chk("err_rst_err", 32'(bus.dmem_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
